// File: rtl/stream_mux_2x1.sv
// stream_mux_2x1: merges two valid/ready packet streams onto one registered output stream.
// A grant is made in IDLE by round-robin among the valid inputs. The mux then stays locked to
// the granted input until that input's last beat is accepted, so packets never interleave.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   en                   enable; gates new grants only (a locked packet always completes)
//   in0_* / in1_*        input streams: data, valid, last, ready
//   out_data/valid/last  registered merged stream
//   out_src              source index of the beat currently in the output register
//   out_ready            downstream ready
//   busy                 high while locked to an input
module stream_mux_2x1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLock0 = 2'd1,
        StLock1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             out_src_q, out_src_d;

    logic can_load;
    logic hs0, hs1;

    // The output register can take a beat when it is empty or being drained this cycle.
    assign can_load  = !out_valid_q || out_ready;
    assign in0_ready = (state_q == StLock0) && can_load;
    assign in1_ready = (state_q == StLock1) && can_load;
    assign hs0       = in0_valid && in0_ready;
    assign hs1       = in1_valid && in1_ready;

    // Arbitration and packet-end tracking
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (en && (in0_valid || in1_valid)) begin
                    // in0 wins when it is the only requester or when it holds the pointer
                    if (in0_valid && (!in1_valid || !rr_ptr_q)) begin
                        state_d = StLock0;
                    end else begin
                        state_d = StLock1;
                    end
                end
            end
            StLock0: begin
                if (hs0 && in0_last) begin
                    state_d  = StIdle;
                    rr_ptr_d = 1'b1;
                end
            end
            StLock1: begin
                if (hs1 && in1_last) begin
                    state_d  = StIdle;
                    rr_ptr_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output register: load on handshake, clear valid on drain, otherwise hold
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (hs0) begin
            out_data_d  = in0_data;
            out_last_d  = in0_last;
            out_src_d   = 1'b0;
            out_valid_d = 1'b1;
        end else if (hs1) begin
            out_data_d  = in1_data;
            out_last_d  = in1_last;
            out_src_d   = 1'b1;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_stream_mux_2x1.sv
// Directed testbench for stream_mux_2x1: per-port beat queues feed the inputs, a monitor
// records accepted output beats, and hand-computed expectations are compared via check_eq.
module tb_stream_mux_2x1;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b1;
    logic [WIDTH-1:0] in0_data = '0;
    logic             in0_valid = 1'b0;
    logic             in0_last = 1'b0;
    logic             in0_ready;
    logic [WIDTH-1:0] in1_data = '0;
    logic             in1_valid = 1'b0;
    logic             in1_last = 1'b0;
    logic             in1_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_src;
    logic             out_ready = 1'b1;
    logic             busy;

    stream_mux_2x1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } in_beat_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        logic             src;
        int               cyc;
    } out_beat_t;

    in_beat_t  q0[$];
    in_beat_t  q1[$];
    out_beat_t mon_q[$];
    int        cyc = 0;
    int        n_cmp = 0;
    int        n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted output beats, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_q.push_back('{data: out_data, last: out_last, src: out_src, cyc: cyc});
        end
    end

    // Input drivers: present the queue head, pop it after a handshake
    initial begin
        logic hs;
        forever begin
            @(negedge clk);
            hs = in0_valid && in0_ready;
            @(posedge clk);
            #1;
            if (hs && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                in0_valid = 1'b1;
                in0_data  = q0[0].data;
                in0_last  = q0[0].last;
            end else begin
                in0_valid = 1'b0;
                in0_last  = 1'b0;
            end
        end
    end

    initial begin
        logic hs;
        forever begin
            @(negedge clk);
            hs = in1_valid && in1_ready;
            @(posedge clk);
            #1;
            if (hs && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                in1_valid = 1'b1;
                in1_data  = q1[0].data;
                in1_last  = q1[0].last;
            end else begin
                in1_valid = 1'b0;
                in1_last  = 1'b0;
            end
        end
    end

    // Main sequence acts 2 time units after each rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic flush();
        q0.delete();
        q1.delete();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_last  = 1'b0;
        in1_last  = 1'b0;
        mon_q.delete();
    endtask

    task automatic do_reset();
        flush();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mon_q.delete();
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (mon_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (mon_q.size() < n) check_eq({tag, "_timeout"}, 32'(mon_q.size()), 32'(n));
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [WIDTH-1:0] d,
                              input logic l, input logic s);
        if (idx >= mon_q.size()) begin
            check_eq({tag, "_missing"}, 32'(mon_q.size()), 32'(idx + 1));
        end else begin
            check_eq({tag, "_data"}, 32'(mon_q[idx].data), 32'(d));
            check_eq({tag, "_last"}, 32'(mon_q[idx].last), 32'(l));
            check_eq({tag, "_src"}, 32'(mon_q[idx].src), 32'(s));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    logic [WIDTH-1:0] exp_cont [8];
    logic [WIDTH-1:0] exp_bp   [4];
    logic [WIDTH-1:0] exp_en   [4];

    initial begin
        exp_cont = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1};
        exp_bp   = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        exp_en   = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};

        // Reset then idle
        step();
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_data", 32'(out_data), 0);
        check_eq("rst_out_last", 32'(out_last), 0);
        check_eq("rst_out_src", 32'(out_src), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_in0_ready", 32'(in0_ready), 0);
        check_eq("rst_in1_ready", 32'(in1_ready), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("idle_busy", 32'(busy), 0);
            check_eq("idle_out_valid", 32'(out_valid), 0);
        end

        // Single source, 3 beats
        q0.push_back('{data: 8'h11, last: 1'b0});
        q0.push_back('{data: 8'h22, last: 1'b0});
        q0.push_back('{data: 8'h33, last: 1'b1});
        step();
        check_eq("ss_in0_valid", 32'(in0_valid), 1);
        check_eq("ss_ready_arb", 32'(in0_ready), 0);
        step();
        check_eq("ss_ready_rise", 32'(in0_ready), 1);
        check_eq("ss_busy", 32'(busy), 1);
        step();
        check_eq("ss_b0_data", 32'(out_data), 32'h11);
        check_eq("ss_b0_valid", 32'(out_valid), 1);
        check_eq("ss_b0_last", 32'(out_last), 0);
        check_eq("ss_b0_src", 32'(out_src), 0);
        step();
        check_eq("ss_b1_data", 32'(out_data), 32'h22);
        check_eq("ss_b1_last", 32'(out_last), 0);
        step();
        check_eq("ss_b2_data", 32'(out_data), 32'h33);
        check_eq("ss_b2_last", 32'(out_last), 1);
        check_eq("ss_busy_fall", 32'(busy), 0);
        step();
        check_eq("ss_drained", 32'(out_valid), 0);

        // Contention round-robin from reset
        do_reset();
        for (int p = 0; p < 2; p++) begin
            q0.push_back('{data: 8'hA0, last: 1'b0});
            q0.push_back('{data: 8'hA1, last: 1'b1});
            q1.push_back('{data: 8'hB0, last: 1'b0});
            q1.push_back('{data: 8'hB1, last: 1'b1});
        end
        wait_beats(8, 40, "rr");
        for (int i = 0; i < 8; i++) begin
            check_beat($sformatf("rr_beat%0d", i), i, exp_cont[i], logic'(i % 2 == 1),
                       logic'((i / 2) % 2 == 1));
        end
        if (mon_q.size() >= 3) begin
            check_eq("rr_in_pkt_gap", 32'(mon_q[1].cyc - mon_q[0].cyc), 1);
            check_eq("rr_pkt_gap", 32'(mon_q[2].cyc - mon_q[1].cyc), 2);
        end

        // Backpressure mid-packet
        do_reset();
        for (int i = 0; i < 4; i++) q0.push_back('{data: exp_bp[i], last: logic'(i == 3)});
        begin
            int k;
            k = 0;
            while (!(out_valid && out_data == 8'hC1) && k < 20) begin
                step();
                k++;
            end
            check_eq("bp_reach_c1", 32'(out_data), 32'hC1);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("bp_hold_data", 32'(out_data), 32'hC1);
            check_eq("bp_in0_ready", 32'(in0_ready), 0);
            step();
        end
        out_ready = 1'b1;
        wait_beats(4, 20, "bp");
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("bp_beat%0d", i), i, exp_bp[i], logic'(i == 3), 1'b0);
        end
        step();
        step();
        check_eq("bp_no_dup", 32'(mon_q.size()), 4);

        // en dropped mid-packet on in1
        do_reset();
        for (int i = 0; i < 4; i++) q1.push_back('{data: exp_en[i], last: logic'(i == 3)});
        begin
            int k;
            k = 0;
            while (!(out_valid && out_data == 8'hD1) && k < 20) begin
                step();
                k++;
            end
            check_eq("en_reach_d1", 32'(out_data), 32'hD1);
        end
        en = 1'b0;
        q0.push_back('{data: 8'hE0, last: 1'b1});
        wait_beats(4, 20, "en");
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("en_beat%0d", i), i, exp_en[i], logic'(i == 3), 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("en_no_grant", 32'(busy), 0);
            check_eq("en_in0_ready", 32'(in0_ready), 0);
        end
        en = 1'b1;
        step();
        check_eq("en_grant", 32'(busy), 1);
        check_eq("en_grant_in0", 32'(in0_ready), 1);
        wait_beats(5, 20, "en_e0");
        check_beat("en_e0", 4, 8'hE0, 1'b1, 1'b0);

        // Async reset mid-packet during LOCK1 (rr_ptr is 1 here after the in0 packet)
        mon_q.delete();
        for (int i = 0; i < 4; i++) q1.push_back('{data: 8'hF4 + 8'(i), last: logic'(i == 3)});
        begin
            int k;
            k = 0;
            while (!(busy && out_valid) && k < 20) begin
                step();
                k++;
            end
            check_eq("ar_locked", 32'(busy && out_valid && in1_ready), 1);
        end
        rst = 1'b1;
        #1;
        check_eq("ar_out_valid", 32'(out_valid), 0);
        check_eq("ar_in1_ready", 32'(in1_ready), 0);
        check_eq("ar_busy", 32'(busy), 0);
        flush();
        #1;
        rst = 1'b0;
        step();
        q0.push_back('{data: 8'hF0, last: 1'b1});
        q1.push_back('{data: 8'hF1, last: 1'b1});
        wait_beats(2, 20, "ar");
        check_beat("ar_first", 0, 8'hF0, 1'b1, 1'b0);
        check_beat("ar_second", 1, 8'hF1, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_2x1.md
Name: stream_mux_2x1

Overview:
- Merges two valid/ready packet streams (in0, in1) onto one output stream. It is the collecting counterpart of the team's 1x2 demux, which splits one stream into two.
- Arbitrates round-robin at packet boundaries and locks onto the granted input until that input's last beat is accepted.
- Has a single registered output stage, so a merge point can be placed anywhere in a datapath without creating combinational valid/ready loops on the data side.

Parameters:
WIDTH, 8, data width of each stream in bits

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  block enable; gates new grants only
in0_data  input  WIDTH  stream 0 payload
in0_valid  input  1  stream 0 beat valid
in0_last  input  1  stream 0 final beat of packet
in0_ready  output  1  stream 0 beat accepted when valid&ready
in1_data  input  WIDTH  stream 1 payload
in1_valid  input  1  stream 1 beat valid
in1_last  input  1  stream 1 final beat of packet
in1_ready  output  1  stream 1 beat accepted when valid&ready
out_data  output  WIDTH  merged payload (registered)
out_valid  output  1  merged beat valid (registered)
out_last  output  1  merged final beat (registered)
out_src  output  1  source index of the current out beat (registered)
out_ready  input  1  downstream accepts when out_valid&out_ready
busy  output  1  high while in a LOCK state

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0.
  - out_valid=0, out_data=0, out_last=0, out_src=0, busy=0.
  - in0_ready=0, in1_ready=0.
- Reset asserted mid-packet discards the partial packet and any held output beat. There is no recovery of the lost beats.
- States: IDLE, LOCK0, LOCK1. busy=1 in LOCK0/LOCK1.
- IDLE:
  - If en=1 and at least one input is valid, a grant is made on the next edge.
  - Only in0 valid -> LOCK0. Only in1 valid -> LOCK1.
  - Both valid -> the input equal to rr_ptr wins.
  - If en=0, or neither input is valid, stay in IDLE.
  - In IDLE both in*_ready=0. This gives a one-cycle arbitration bubble per packet.
- LOCKx:
  - inx_ready = !out_valid | out_ready (combinational). The non-granted input's ready is 0.
  - Handshake on inx loads the output register on the next edge: out_data=inx_data, out_last=inx_last, out_src=x, out_valid=1.
  - Latency from input handshake to out_valid is 1 cycle.
  - Throughput is 1 beat/cycle while out_ready=1.
- Output register:
  - If out_valid&out_ready with no new input beat, out_valid goes to 0.
  - If out_valid=1 and out_ready=0, out_data, out_last and out_src hold stable. inx_ready=0 in that cycle.
  - Simultaneous drain and load: the register takes the new beat and out_valid stays 1.
- Packet end:
  - The handshake of a beat with inx_last=1 moves the state LOCKx -> IDLE and sets rr_ptr = !x on the same edge.
  - The next arbitration happens in IDLE even if the output register still holds the last beat.
- A single-beat packet (valid with last=1 on the first beat) is legal. It costs 1 beat cycle plus the 1 arbitration cycle.
- en:
  - Deasserting en during LOCKx does not stop the current packet. The packet runs to its last beat, then the block stays IDLE until en=1.
  - en does not gate draining of the output register.
- Input protocol: data, last and valid must hold while valid=1 and ready=0. The block relies on this and does not check it.
- Packet atomicity: beats of different packets never interleave on the output, and out_src is constant across a packet.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, release, no valids, en=1.
  - Required: all outputs 0, state stays IDLE for 10 cycles.
- Single source:
  - Stimulus: in0 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33), out_ready=1.
  - Required: in0_ready rises 1 cycle after valid. out shows 0x11, 0x22, 0x33 on 3 consecutive cycles with out_src=0 and out_last only on 0x33. busy falls after the 0x33 handshake.
- Contention round-robin:
  - Stimulus: in0 and in1 both present 2-beat packets continuously (in0: 0xA0, 0xA1; in1: 0xB0, 0xB1) from reset.
  - Required: output order is 0xA0, 0xA1, 0xB0, 0xB1, 0xA0, ... with a 1-cycle gap between packets.
- Backpressure:
  - Stimulus: mid-packet, hold out_ready=0 for 4 cycles.
  - Required: out_data stable and in0_ready=0 during the stall. No beat is lost or duplicated after release.
- en mid-packet:
  - Stimulus: drop en on beat 2 of a 4-beat in1 packet.
  - Required: all 4 beats are delivered, then no grant while en=0 even with in0_valid=1. The in0 grant occurs 1 cycle after en returns.
- Async reset mid-packet:
  - Stimulus: pulse rst between clock edges during LOCK1.
  - Required: out_valid, in*_ready and busy go to 0 immediately, without waiting for a clock edge. The next packet is granted to in0 (rr_ptr=0).
